// File: rtl/pattern_timer_gen.sv
// pattern_timer_gen: serial start-pattern detector followed by a delay-field
// shifter and a unit-scaled countdown timer that raises done until acked.
// Optional build macro: PATTERN_TIMER_ABORT_EN adds an abort input that
// cancels a pending SHIFT or COUNT and returns the block to SEARCH.
module pattern_timer_gen #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                 DLY_W       = 4,
  parameter int                 UNIT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data,
  input  logic             ack,
`ifdef PATTERN_TIMER_ABORT_EN
  input  logic             abort,
`endif
  output logic             shift_ena,
  output logic             counting,
  output logic             done,
  output logic [DLY_W-1:0] remaining
);

  // The match window is the stored PAT_LEN-1 previous bits plus the live
  // data bit, so only PAT_LEN-1 bits need to be registered.
  localparam int HIST_W = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
  localparam int BIT_W  = (DLY_W > 1) ? $clog2(DLY_W) : 1;
  localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  // Three-bit encoding leaves spare codes; any of them falls back to SEARCH.
  localparam logic [2:0] ST_SEARCH = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_COUNT  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;

  logic [2:0]         state_reg, state_next;
  logic [HIST_W-1:0]  hist_reg, hist_next;
  logic [DLY_W-1:0]   dly_reg, dly_next;     // delay field, then units left
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [UNIT_W-1:0]  unit_cnt_reg, unit_cnt_next;

  logic [PAT_LEN-1:0] window;
  logic [DLY_W-1:0]   dly_shift;
  logic               unit_end;
  logic               abort_w;

`ifdef PATTERN_TIMER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Candidate pattern window: newest bit in the LSB, oldest in the MSB.
  assign window[0] = data;
  generate
    for (genvar gi = 1; gi < PAT_LEN; gi++) begin : g_window
      assign window[gi] = hist_reg[gi-1];
    end
  endgenerate

  // Delay field is received MSB first, so shift towards the MSB.
  assign dly_shift[0] = data;
  generate
    for (genvar gi = 1; gi < DLY_W; gi++) begin : g_dly_shift
      assign dly_shift[gi] = dly_reg[gi-1];
    end
  endgenerate

  // With one cycle per unit the sub-unit counter is not needed at all.
  generate
    if (UNIT_CYCLES == 1) begin : g_unit_bypass
      assign unit_end = 1'b1;
    end else begin : g_unit_count
      assign unit_end = (unit_cnt_reg == UNIT_W'(UNIT_CYCLES - 1));
    end
  endgenerate

  // Next-state logic: history is only non-zero while in SEARCH, so every
  // return to SEARCH starts with a clean window.
  always_comb begin
    state_next    = state_reg;
    hist_next     = hist_reg;
    dly_next      = dly_reg;
    bit_cnt_next  = bit_cnt_reg;
    unit_cnt_next = unit_cnt_reg;
    case (state_reg)
      ST_SEARCH: begin
        if (window == PATTERN) begin
          state_next   = ST_SHIFT;
          hist_next    = '0;
          dly_next     = '0;
          bit_cnt_next = '0;
        end else begin
          hist_next = window[HIST_W-1:0];
        end
      end
      ST_SHIFT: begin
        if (abort_w) begin
          state_next = ST_SEARCH;
          hist_next  = '0;
        end else begin
          dly_next     = dly_shift;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_W'(DLY_W - 1)) begin
            state_next    = ST_COUNT;
            unit_cnt_next = '0;
          end
        end
      end
      ST_COUNT: begin
        if (abort_w) begin
          state_next = ST_SEARCH;
          hist_next  = '0;
        end else if (unit_end) begin
          unit_cnt_next = '0;
          if (dly_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            dly_next = dly_reg - 1'b1;
          end
        end else begin
          unit_cnt_next = unit_cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_next = ST_SEARCH;
          hist_next  = '0;
          dly_next   = '0;
        end
      end
      default: begin
        state_next    = ST_SEARCH;
        hist_next     = '0;
        dly_next      = '0;
        bit_cnt_next  = '0;
        unit_cnt_next = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_SEARCH;
      hist_reg     <= '0;
      dly_reg      <= '0;
      bit_cnt_reg  <= '0;
      unit_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hist_reg     <= hist_next;
      dly_reg      <= dly_next;
      bit_cnt_reg  <= bit_cnt_next;
      unit_cnt_reg <= unit_cnt_next;
    end
  end

  // Moore outputs decoded from the registered state only.
  assign shift_ena = (state_reg == ST_SHIFT);
  assign counting  = (state_reg == ST_COUNT);
  assign done      = (state_reg == ST_DONE);
  assign remaining = (state_reg == ST_COUNT) ? dly_reg : '0;

endmodule
